accel_run_sequencer: RTL and testbench

ACCEL_RUN_SEQUENCER -- requirements
Module: accel_run_sequencer

---
 rtl/accel_run_sequencer.sv | 178 +++++++++++++++++
 tb/tb_accel_run_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_run_sequencer.sv
// rtl/accel_run_sequencer.sv - load bytes into accelerator slave RAM, start it, time the run
//
// Sequences one accelerator run:
//   IDLE -> LOAD/WAIT_ACK (LOAD_LEN bytes) -> START -> RUN -> DONE -> IDLE
//
// Parameters
//   BASE_ADDR       first slave-RAM byte address written during load (mod 128)
//   LOAD_LEN        bytes loaded per run; 0 skips the load phase
//   TIMEOUT_CYCLES  watchdog limit in clock cycles (only with ACCEL_SEQ_TIMEOUT_EN)
//
// Ports
//   clock, reset                 single clock, asynchronous active-low reset
//   go                           run request, sampled in IDLE only
//   ld_valid/ld_data/ld_ready    load byte stream (accepted in LOAD only)
//   sl_we/sl_addr/sl_wdata/sl_size, sl_rdy
//                                slave-RAM write request and its acknowledge
//   start_port/done_port         accelerator start pulse and completion
//   busy/run_done/cycles/timeout_err
//                                status
//
// Build option
//   ACCEL_SEQ_TIMEOUT_EN  when defined, RUN gives up after TIMEOUT_CYCLES and
//                         flags timeout_err; when undefined RUN waits forever
//                         and timeout_err is tied low.

module accel_run_sequencer #(
    parameter int BASE_ADDR      = 0,
    parameter int LOAD_LEN       = 64,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        sl_we,
    output logic [6:0]  sl_addr,
    output logic [7:0]  sl_wdata,
    output logic [3:0]  sl_size,
    input  logic        sl_rdy,
    output logic        start_port,
    input  logic        done_port,
    output logic        busy,
    output logic        run_done,
    output logic [31:0] cycles,
    output logic        timeout_err
);

    // Index must be able to hold LOAD_LEN itself; +2 keeps the width >= 1 for LOAD_LEN=0.
    localparam int             IW     = $clog2(LOAD_LEN + 2);
    localparam logic [IW-1:0]  LEN_W  = IW'(LOAD_LEN);
    localparam logic [6:0]     BASE_W = 7'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_ACK,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] index;
    logic [6:0]    addr_q;
    logic [7:0]    wdata_q;
    logic [31:0]   cycles_q;

    logic          accept;
    logic [6:0]    addr_now;
    logic [IW-1:0] index_inc;
    logic [31:0]   cycles_inc;
    logic          limit_hit;

    assign accept     = (state == S_LOAD) && ld_valid;
    assign addr_now   = BASE_W + 7'(index);
    assign index_inc  = index + IW'(1);
    assign cycles_inc = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;

`ifdef ACCEL_SEQ_TIMEOUT_EN
    localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES);

    logic timeout_q;

    // Compared against the post-increment count so cycles reads exactly the limit in DONE.
    assign limit_hit   = (cycles_inc >= LIMIT);
    assign timeout_err = timeout_q;
`else
    // Watchdog compiled out; the parameter stays so both builds share one instantiation.
    if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
    end

    assign limit_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            index    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cycles_q <= '0;
`ifdef ACCEL_SEQ_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        index <= '0;
`ifdef ACCEL_SEQ_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        if (LOAD_LEN == 0) begin
                            state    <= S_START;
                            cycles_q <= '0;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        // Capture the request so it stays stable while waiting for the ack.
                        addr_q  <= addr_now;
                        wdata_q <= ld_data;
                        state   <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (sl_rdy) begin
                        index <= index_inc;
                        if (index_inc == LEN_W) begin
                            state    <= S_START;
                            cycles_q <= '0;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_START: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    // The completing cycle is counted: done in the first RUN cycle gives 1.
                    cycles_q <= cycles_inc;
                    if (done_port) begin
                        state <= S_DONE;
                    end else if (limit_hit) begin
                        state <= S_DONE;
`ifdef ACCEL_SEQ_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ld_ready   = (state == S_LOAD);
    assign sl_we      = accept;
    assign sl_addr    = accept ? addr_now : addr_q;
    assign sl_wdata   = accept ? ld_data : wdata_q;
    assign sl_size    = ((state == S_LOAD) || (state == S_WAIT_ACK)) ? 4'd8 : 4'd0;
    assign start_port = (state == S_START);
    assign run_done   = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_accel_run_sequencer.sv
// tb/tb_accel_run_sequencer.sv - directed self-checking bench for accel_run_sequencer

module tb_accel_run_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        go, go0;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        sl_rdy;
    logic        done_port, done0;

    logic        ld_ready, sl_we, start_port, busy, run_done, timeout_err;
    logic [6:0]  sl_addr;
    logic [7:0]  sl_wdata;
    logic [3:0]  sl_size;
    logic [31:0] cycles;

    logic        ld_ready0, sl_we0, start0, busy0, run_done0, timeout_err0;
    logic [6:0]  sl_addr0;
    logic [7:0]  sl_wdata0;
    logic [3:0]  sl_size0;
    logic [31:0] cycles0;

    int total = 0;
    int bad   = 0;
    int starts = 0;
    int we0_cnt = 0;
    logic [14:0] exp_q[$];

    always #5 clock = ~clock;

    accel_run_sequencer #(.BASE_ADDR(16), .LOAD_LEN(4), .TIMEOUT_CYCLES(20)) dut (
        .clock(clock), .reset(reset), .go(go),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .sl_we(sl_we), .sl_addr(sl_addr), .sl_wdata(sl_wdata), .sl_size(sl_size),
        .sl_rdy(sl_rdy), .start_port(start_port), .done_port(done_port),
        .busy(busy), .run_done(run_done), .cycles(cycles), .timeout_err(timeout_err)
    );

    accel_run_sequencer #(.BASE_ADDR(16), .LOAD_LEN(0), .TIMEOUT_CYCLES(20)) dut0 (
        .clock(clock), .reset(reset), .go(go0),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready0),
        .sl_we(sl_we0), .sl_addr(sl_addr0), .sl_wdata(sl_wdata0), .sl_size(sl_size0),
        .sl_rdy(sl_rdy), .start_port(start0), .done_port(done0),
        .busy(busy0), .run_done(run_done0), .cycles(cycles0), .timeout_err(timeout_err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge (combinational write strobe), then advance past the rising edge.
    task automatic step();
        logic [14:0] e;
        @(negedge clock);
        if (sl_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(sl_addr), 32'(e[14:8]));
                chk("wr_data", 32'(sl_wdata), 32'(e[7:0]));
                chk("wr_size", 32'(sl_size), 32'd8);
            end
        end
        if (start_port) starts++;
        if (sl_we0) we0_cnt++;
        @(posedge clock);
        #1;
    endtask

    task automatic load_four(input logic [7:0] base_data);
        go = 1'b1;
        step();
        go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = base_data + 8'(i);
            exp_q.push_back({7'(16 + i), ld_data});
            step();
            ld_valid = 1'b0;
            sl_rdy   = 1'b1;
            step();
            sl_rdy   = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       found;

        reset = 1'b0; go = 1'b0; go0 = 1'b0; ld_valid = 1'b1; ld_data = 8'h55;
        sl_rdy = 1'b0; done_port = 1'b0; done0 = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_sl_we", 32'(sl_we), 32'd0);
        chk("rst_sl_size", 32'(sl_size), 32'd0);
        chk("rst_start", 32'(start_port), 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        ld_valid = 1'b0;
        reset = 1'b1;

        // LOAD_LEN=0 instance: straight to START, no writes.
        go0 = 1'b1;
        chk("len0_no_start_yet", 32'(start0), 32'd0);
        step();
        go0 = 1'b0;
        chk("len0_start", 32'(start0), 32'd1);
        step();
        chk("len0_start_one_cycle", 32'(start0), 32'd0);
        done0 = 1'b1;
        step();
        done0 = 1'b0;
        chk("len0_run_done", 32'(run_done0), 32'd1);
        chk("len0_cycles", cycles0, 32'd1);
        step();
        chk("len0_idle", 32'(busy0), 32'd0);

        // Load 0xA1..0xA4 at 16..19, ack two cycles after each write.
        go = 1'b1;
        step();
        go = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_ready", 32'(ld_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'hA1 + 8'(i);
            exp_q.push_back({7'(16 + i), ld_data});
            step();
            ld_data = 8'hEE;
            chk("wait_ready", 32'(ld_ready), 32'd0);
            chk("wait_we", 32'(sl_we), 32'd0);
            chk("wait_addr_held", 32'(sl_addr), 32'(16 + i));
            chk("wait_data_held", 32'(sl_wdata), 32'(8'hA1 + 8'(i)));
            step();
            ld_valid = 1'b0;
            sl_rdy   = 1'b1;
            step();
            sl_rdy   = 1'b0;
            if (i < 3) chk("no_early_start", 32'(start_port), 32'd0);
        end
        chk("start_after_4th_ack", 32'(start_port), 32'd1);
        chk("start_cycles_clear", cycles, 32'd0);
        for (int i = 0; i < 10; i++) step();
        chk("run_cycles_before_done", cycles, 32'd9);
        done_port = 1'b1;
        step();
        done_port = 1'b0;
        chk("run_done_pulse", 32'(run_done), 32'd1);
        chk("run_cycles", cycles, 32'd10);
        chk("done_busy", 32'(busy), 32'd1);
        done_port = 1'b1;
        sl_rdy    = 1'b1;
        step();
        chk("run_done_one_cycle", 32'(run_done), 32'd0);
        chk("busy_drops", 32'(busy), 32'd0);
        step();
        done_port = 1'b0;
        sl_rdy    = 1'b0;
        chk("idle_ignores_done", 32'(busy), 32'd0);
        chk("cycles_held", cycles, 32'd10);
        chk("timeout_clear_run1", 32'(timeout_err), 32'd0);

        // Reset in WAIT_ACK of the second byte.
        go = 1'b1;
        step();
        go = 1'b0;
        ld_valid = 1'b1; ld_data = 8'hB1;
        exp_q.push_back({7'd16, 8'hB1});
        step();
        ld_valid = 1'b0; sl_rdy = 1'b1;
        step();
        sl_rdy = 1'b0; ld_valid = 1'b1; ld_data = 8'hB2;
        exp_q.push_back({7'd17, 8'hB2});
        step();
        ld_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_addr", 32'(sl_addr), 32'd0);
        chk("async_rst_data", 32'(sl_wdata), 32'd0);
        chk("async_rst_size", 32'(sl_size), 32'd0);
        chk("async_rst_cycles", cycles, 32'd0);
        step();
        reset = 1'b1;

        // go, ld_valid, sl_rdy, done_port all stuck high: 12-cycle runs back to back.
        starts = 0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 12; k++) begin
                go = 1'b1; ld_valid = 1'b1; sl_rdy = 1'b1; done_port = 1'b1;
                d = 8'h30 + 8'(r * 16 + k);
                ld_data = d;
                if (k == 1 || k == 3 || k == 5 || k == 7)
                    exp_q.push_back({7'(16 + (k - 1) / 2), d});
                if (k == 0) chk("b2b_idle", 32'(busy), 32'd0);
                if (k == 9) begin
                    chk("b2b_start", 32'(start_port), 32'd1);
                    chk("b2b_cycles_clear", cycles, 32'd0);
                end
                if (k == 11) begin
                    chk("b2b_run_done", 32'(run_done), 32'd1);
                    chk("b2b_cycles", cycles, 32'd1);
                end
                step();
            end
        end
        go = 1'b0; ld_valid = 1'b0; sl_rdy = 1'b0; done_port = 1'b0;
        step();
        chk("b2b_start_count", 32'(starts), 32'd3);
        chk("writes_drained", 32'(exp_q.size()), 32'd0);

`ifdef ACCEL_SEQ_TIMEOUT_EN
        load_four(8'hC1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (run_done) found = 1'b1;
        end
        chk("timeout_reached", 32'(found), 32'd1);
        chk("timeout_cycles", cycles, 32'd20);
        chk("timeout_flag", 32'(timeout_err), 32'd1);
        step();
        chk("timeout_sticky", 32'(timeout_err), 32'd1);
        go = 1'b1;
        step();
        go = 1'b0;
        chk("timeout_cleared_by_go", 32'(timeout_err), 32'd0);
`else
        load_four(8'hC1);
        found = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (run_done) found = 1'b1;
        end
        chk("no_watchdog_done", 32'(found), 32'd0);
        chk("no_watchdog_busy", 32'(busy), 32'd1);
        chk("no_watchdog_cycles", cycles, 32'd24);
        chk("no_watchdog_flag", 32'(timeout_err), 32'd0);
        done_port = 1'b1;
        step();
        done_port = 1'b0;
        chk("late_done", 32'(run_done), 32'd1);
        chk("late_cycles", cycles, 32'd25);
`endif
        chk("len0_never_writes", 32'(we0_cnt), 32'd0);
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
